pawn_move_exec: RTL and testbench
=================================

Name: pawn_move_exec

Overview:
- Sequential move executor that owns the live 8x8 board register and applies pawn moves requested by the game controller.
- Sits directly downstream of the pawn move checker. It drives the checker's row/column/color/board inputs and consumes its 3-bit allow vector.
- Commits legal moves (including capture and promotion), tracks side to move, and returns a status response over a valid/ready handshake.

Parameters:
PROMOTE_TYPE, 3'b101, piece type written when a pawn reaches the far row (default queen)
ENFORCE_TURN, 1, 1 = reject a request whose source pawn is not of the side to move; 0 = either side may move

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
new_game  in  1  sync pulse: reload start position, turn = white, abort any in-flight request without response
req_valid  in  1  move request valid
req_ready  out  1  high only in IDLE
req_row  in  3  source row (0 = top)
req_col  in  3  source column (0 = left)
req_dir  in  2  00 forward, 01 diagLeft (col-1), 10 diagRight (col+1), 11 illegal
chk_row  out  3  to checker: registered source row
chk_col  out  3  to checker: registered source column
chk_color  out  1  to checker: bit1 of the source square
chk_allow  in  3  from checker: [2] forward, [1] diagLeft, [0] diagRight
board  out  5 x [7:0][7:0]  live board, same 5-bit encoding as the checker (bit0 occupied, bit1 color with black = 1, [4:2] type); also feeds the checker boardPos
turn  out  1  side to move, 0 white / 1 black
resp_valid  out  1  response valid, held until resp_ready
resp_ready  in  1  response accepted
resp_err  out  2  00 ok, 01 not own pawn, 10 move disallowed, 11 bad dir
resp_captured  out  5  prior destination contents (00000 if none or rejected)
resp_promo  out  1  move caused promotion

Behaviour:
- Reset (async, rst_n = 0) sets:
  - board to the start position:
    - row 0 black back rank R N B Q K B N R = 10011,01011,01111,10111,11011,01111,01011,10011
    - row 1 all 00111 (black pawn)
    - rows 2-5 all 00000
    - row 6 all 00101 (white pawn)
    - row 7 white back rank = 10001,01001,01101,10101,11001,01101,01001,10001
  - turn = 0, state = IDLE, resp_valid = 0, resp_err = 00, resp_captured = 0, resp_promo = 0, chk_* = 0.
- FSM states: IDLE, CHECK, COMMIT, RESP.
- IDLE: req_ready = 1. On req_valid, register row/col/dir, go to CHECK.
- CHECK (one cycle): chk_row/chk_col come from the request registers and chk_color = board[row][col][1]; the checker output is sampled at the end of this cycle. Error priority:
  - dir == 11 -> err 11
  - source bit0 = 0, type != 001, or (ENFORCE_TURN and color != turn) -> err 01
  - selected chk_allow bit = 0 -> err 10
  - otherwise go to COMMIT.
  - Any error goes to RESP.
- Destination square:
  - row: white row-1, black row+1.
  - column: col (forward), col-1 (diagLeft), col+1 (diagRight).
  - Out-of-range destinations cannot occur, because the checker returns 0 for them.
- COMMIT (one cycle), at its closing edge:
  - resp_captured = old destination contents.
  - Destination = source piece. If the destination row is 0 (white) or 7 (black), write {PROMOTE_TYPE, color, 1} and set resp_promo = 1.
  - Source square = 00000.
  - turn toggles; go to RESP.
  - Board and turn are unchanged on any rejected request.
- RESP: resp_valid = 1, and resp_* are stable until the cycle resp_ready = 1, then go to IDLE.
  - resp_valid and resp_* clear on the RESP -> IDLE edge.
  - resp_ready while not in RESP is ignored.
- Latency: accept edge T; CHECK cycle T..T+1; board updates at edge T+2; resp_valid high from T+2 (reject) or T+3 (commit).
- new_game in any state: next edge loads the start position, turn = 0, state = IDLE, resp_valid = 0. It overrides a same-cycle req_valid (request not accepted) and a same-cycle COMMIT write.
- Reset asserted mid-operation: immediate return to the reset values; no partial board write survives.
- Back-to-back requests: the next request can be accepted in the cycle after RESP completes (IDLE). No request is buffered while busy.

Test Plan:
- Reset, then request white pawn at (6,4) dir 00 -> err 00; board[5][4] = 00101, board[6][4] = 00000, turn = 1, captured 00000, resp_valid at T+3.
- With turn = 0, request black pawn (1,3) dir 00 and ENFORCE_TURN = 1 -> err 01; board unchanged; turn stays 0.
- Place black pawn at (5,3) (via prior legal moves) then white (6,4) dir 01 -> err 00, captured 00111, board[5][3] = 00101.
- White pawn at (1,2) with (0,2) empty, dir 00 -> board[0][2] = 10101, resp_promo = 1, source cleared.
- White (6,0) dir 01, and white (6,4) dir 11 -> err 10 and err 11 respectively; board unchanged.
- new_game asserted during COMMIT cycle, and rst_n pulled low while in CHECK -> start position restored, turn = 0, resp_valid = 0, req_ready = 1 next cycle; hold resp_ready = 0 for 5 cycles in RESP -> outputs stable.

Source files
------------

// File: rtl/pawn_move_exec.sv
//==============================================================================
// pawn_move_exec : owns the live board and commits pawn moves vetted by the
//                  external pawn move checker. Revision 1.0
//==============================================================================
`default_nettype none

module pawn_move_exec #(
  parameter logic [2:0] PROMOTE_TYPE = 3'b101,
  parameter bit         ENFORCE_TURN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  new_game,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_row,
  input  logic [2:0]            req_col,
  input  logic [1:0]            req_dir,
  output logic [2:0]            chk_row,
  output logic [2:0]            chk_col,
  output logic                  chk_color,
  input  logic [2:0]            chk_allow,
  output logic [7:0][7:0][4:0]  board,
  output logic                  turn,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_err,
  output logic [4:0]            resp_captured,
  output logic                  resp_promo
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  function automatic logic [7:0][7:0][4:0] start_pos();
    logic [7:0][7:0][4:0] b;
    logic [2:0]           t;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0, 7:    t = 3'b100;
        1, 6:    t = 3'b010;
        2, 5:    t = 3'b011;
        3:       t = 3'b101;
        default: t = 3'b110;
      endcase
      b[0][c] = {t, 2'b11};
      b[1][c] = 5'b00111;
      b[6][c] = 5'b00101;
      b[7][c] = {t, 2'b01};
    end
    return b;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [2:0]           row_q, row_d, col_q, col_d;
  logic [1:0]           dir_q, dir_d;
  logic [7:0][7:0][4:0] board_q, board_d;
  logic                 turn_q, turn_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [1:0]           resp_err_q, resp_err_d;
  logic [4:0]           resp_captured_q, resp_captured_d;
  logic                 resp_promo_q, resp_promo_d;

  logic [4:0] src;
  logic       src_color;
  logic [2:0] dest_row, dest_col;
  logic       allow_sel, not_own, promo;
  logic [1:0] check_err;

  always_comb begin
    src       = board_q[row_q][col_q];
    src_color = src[1];
    dest_row  = src_color ? row_q + 3'd1 : row_q - 3'd1;
    promo     = (dest_row == (src_color ? 3'd7 : 3'd0));
    not_own   = !src[0] || (src[4:2] != 3'b001) || (ENFORCE_TURN && (src_color != turn_q));
    case (dir_q)
      2'b00:   begin dest_col = col_q;         allow_sel = chk_allow[2]; end
      2'b01:   begin dest_col = col_q - 3'd1;  allow_sel = chk_allow[1]; end
      2'b10:   begin dest_col = col_q + 3'd1;  allow_sel = chk_allow[0]; end
      default: begin dest_col = col_q;         allow_sel = 1'b0;         end
    endcase
    if (dir_q == 2'b11)  check_err = 2'b11;
    else if (not_own)    check_err = 2'b01;
    else if (!allow_sel) check_err = 2'b10;
    else                 check_err = 2'b00;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state; resp_valid rises one cycle after entering RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_CHECK;
      S_CHECK:  state_d = (check_err != 2'b00) ? S_RESP : S_COMMIT;
      S_COMMIT: state_d = S_RESP;
      S_RESP:   if (resp_valid_q && resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (new_game) state_d = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    chk_color = (state_q == S_CHECK) ? src_color : 1'b0;
  end

  always_comb begin
    row_d           = row_q;
    col_d           = col_q;
    dir_d           = dir_q;
    board_d         = board_q;
    turn_d          = turn_q;
    resp_valid_d    = resp_valid_q;
    resp_err_d      = resp_err_q;
    resp_captured_d = resp_captured_q;
    resp_promo_d    = resp_promo_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !new_game) begin
          row_d = req_row;
          col_d = req_col;
          dir_d = req_dir;
        end
      end
      S_CHECK: begin
        resp_err_d      = check_err;
        resp_captured_d = '0;
        resp_promo_d    = 1'b0;
      end
      S_COMMIT: begin
        resp_err_d      = 2'b00;
        resp_captured_d = board_q[dest_row][dest_col];
        resp_promo_d    = promo;
        board_d[dest_row][dest_col] = promo ? {PROMOTE_TYPE, src_color, 1'b1} : src;
        board_d[row_q][col_q]       = '0;
        turn_d          = ~turn_q;
      end
      S_RESP: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d    = 1'b0;
          resp_err_d      = 2'b00;
          resp_captured_d = '0;
          resp_promo_d    = 1'b0;
        end else begin
          resp_valid_d    = 1'b1;
        end
      end
      default: ;
    endcase
    if (new_game) begin
      board_d         = start_pos();
      turn_d          = 1'b0;
      resp_valid_d    = 1'b0;
      resp_err_d      = 2'b00;
      resp_captured_d = '0;
      resp_promo_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q           <= '0;
      col_q           <= '0;
      dir_q           <= '0;
      board_q         <= start_pos();
      turn_q          <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 2'b00;
      resp_captured_q <= '0;
      resp_promo_q    <= 1'b0;
    end else begin
      row_q           <= row_d;
      col_q           <= col_d;
      dir_q           <= dir_d;
      board_q         <= board_d;
      turn_q          <= turn_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_captured_q <= resp_captured_d;
      resp_promo_q    <= resp_promo_d;
    end
  end

  assign chk_row       = row_q;
  assign chk_col       = col_q;
  assign board         = board_q;
  assign turn          = turn_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_captured = resp_captured_q;
  assign resp_promo    = resp_promo_q;

endmodule

`default_nettype wire

// File: tb/tb_pawn_move_exec.sv
//==============================================================================
// tb_pawn_move_exec : directed bench; the bench plays the role of the checker.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_pawn_move_exec;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 new_game = 1'b0;
  logic                 req_valid = 1'b0;
  logic [2:0]           req_row = '0;
  logic [2:0]           req_col = '0;
  logic [1:0]           req_dir = '0;
  logic [2:0]           chk_allow = '0;
  logic                 resp_ready = 1'b0;
  logic                 req_ready;
  logic [2:0]           chk_row, chk_col;
  logic                 chk_color;
  logic [7:0][7:0][4:0] board;
  logic                 turn;
  logic                 resp_valid;
  logic [1:0]           resp_err;
  logic [4:0]           resp_captured;
  logic                 resp_promo;

  pawn_move_exec #(.PROMOTE_TYPE(3'b101), .ENFORCE_TURN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_dir(req_dir),
    .chk_row(chk_row), .chk_col(chk_col), .chk_color(chk_color), .chk_allow(chk_allow),
    .board(board), .turn(turn),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .resp_captured(resp_captured), .resp_promo(resp_promo)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [7:0][7:0][4:0] start_b, exp_b;
  logic                 exp_turn;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request: hand-computed error, destination, capture and promotion.
  task automatic run_step(input string name, input logic [2:0] r, input logic [2:0] c,
                          input logic [1:0] d, input logic [2:0] allow, input logic [1:0] err,
                          input logic [2:0] dr, input logic [2:0] dc, input logic [4:0] cap,
                          input logic promo, input bit hold);
    int         lat;
    logic [4:0] src;
    src = exp_b[r][c];
    @(negedge clk);
    check({name, ".ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_row = r; req_col = c; req_dir = d; chk_allow = allow;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, ".chk_row"}, chk_row, r);
    check({name, ".chk_col"}, chk_col, c);
    check({name, ".chk_color"}, chk_color, src[1]);
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    check({name, ".latency"}, lat, (err == 2'b00) ? 3 : 2);
    check({name, ".err"}, resp_err, err);
    check({name, ".captured"}, resp_captured, cap);
    check({name, ".promo"}, resp_promo, promo);
    if (err == 2'b00) begin
      exp_b[dr][dc] = promo ? {3'b101, src[1], 1'b1} : src;
      exp_b[r][c]   = 5'b00000;
      exp_turn      = ~exp_turn;
    end
    check({name, ".board"}, board, exp_b);
    check({name, ".turn"}, turn, exp_turn);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({name, ".hold_valid"}, resp_valid, 1'b1);
        check({name, ".hold_err"}, resp_err, err);
        check({name, ".hold_cap"}, resp_captured, cap);
      end
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); resp_ready = 1'b0;
    check({name, ".valid_clr"}, resp_valid, 1'b0);
    check({name, ".err_clr"}, resp_err, 2'b00);
    check({name, ".idle"}, req_ready, 1'b1);
  endtask

  initial begin
    start_b    = '0;
    start_b[0] = {5'b10011, 5'b01011, 5'b01111, 5'b11011, 5'b10111, 5'b01111, 5'b01011, 5'b10011};
    start_b[1] = {8{5'b00111}};
    start_b[6] = {8{5'b00101}};
    start_b[7] = {5'b10001, 5'b01001, 5'b01101, 5'b11001, 5'b10101, 5'b01101, 5'b01001, 5'b10001};
    exp_b      = start_b;
    exp_turn   = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    check("rst.board", board, start_b);
    check("rst.turn", turn, 1'b0);
    check("rst.valid", resp_valid, 1'b0);
    check("rst.ready", req_ready, 1'b1);
    check("rst.chk_color", chk_color, 1'b0);
    check("rst.captured", resp_captured, 5'd0);
    @(negedge clk) rst_n = 1'b1;

    run_step("s00", 3'd1, 3'd3, 2'b00, 3'b100, 2'b01, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s01", 3'd6, 3'd4, 2'b00, 3'b100, 2'b00, 3'd5, 3'd4, 5'b00000, 1'b0, 1'b0);

    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
    exp_b = start_b; exp_turn = 1'b0;
    check("ng.board", board, start_b);
    check("ng.turn", turn, 1'b0);

    run_step("s02", 3'd6, 3'd7, 2'b00, 3'b100, 2'b00, 3'd5, 3'd7, 5'b00000, 1'b0, 1'b0);
    run_step("s03", 3'd1, 3'd3, 2'b00, 3'b100, 2'b00, 3'd2, 3'd3, 5'b00000, 1'b0, 1'b0);
    run_step("s04", 3'd5, 3'd7, 2'b00, 3'b100, 2'b00, 3'd4, 3'd7, 5'b00000, 1'b0, 1'b0);
    run_step("s05", 3'd2, 3'd3, 2'b00, 3'b100, 2'b00, 3'd3, 3'd3, 5'b00000, 1'b0, 1'b0);
    run_step("s06", 3'd4, 3'd7, 2'b00, 3'b100, 2'b00, 3'd3, 3'd7, 5'b00000, 1'b0, 1'b0);
    run_step("s07", 3'd3, 3'd3, 2'b00, 3'b100, 2'b00, 3'd4, 3'd3, 5'b00000, 1'b0, 1'b0);
    run_step("s08", 3'd3, 3'd7, 2'b00, 3'b100, 2'b00, 3'd2, 3'd7, 5'b00000, 1'b0, 1'b0);
    run_step("s09", 3'd4, 3'd3, 2'b00, 3'b100, 2'b00, 3'd5, 3'd3, 5'b00000, 1'b0, 1'b0);
    run_step("s10", 3'd6, 3'd4, 2'b01, 3'b010, 2'b00, 3'd5, 3'd3, 5'b00111, 1'b0, 1'b0);
    run_step("s11", 3'd1, 3'd0, 2'b00, 3'b100, 2'b00, 3'd2, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s12", 3'd2, 3'd7, 2'b01, 3'b010, 2'b00, 3'd1, 3'd6, 5'b00111, 1'b0, 1'b0);
    run_step("s13", 3'd2, 3'd0, 2'b00, 3'b100, 2'b00, 3'd3, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s14", 3'd1, 3'd6, 2'b01, 3'b010, 2'b00, 3'd0, 3'd5, 5'b01111, 1'b1, 1'b0);
    check("s14.queen", board[0][5], 5'b10101);
    run_step("s15", 3'd3, 3'd0, 2'b00, 3'b100, 2'b00, 3'd4, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s16", 3'd6, 3'd0, 2'b01, 3'b000, 2'b10, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s17", 3'd6, 3'd4, 2'b11, 3'b111, 2'b11, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s18", 3'd4, 3'd0, 2'b00, 3'b100, 2'b01, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s19", 3'd7, 3'd3, 2'b00, 3'b100, 2'b01, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s20", 3'd4, 3'd4, 2'b00, 3'b100, 2'b01, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s21", 3'd6, 3'd1, 2'b00, 3'b011, 2'b10, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0);
    run_step("s22", 3'd6, 3'd1, 2'b10, 3'b011, 2'b00, 3'd5, 3'd2, 5'b00000, 1'b0, 1'b0);
    run_step("s23", 3'd1, 3'd1, 2'b00, 3'b100, 2'b00, 3'd2, 3'd1, 5'b00000, 1'b0, 1'b1);

    // new_game landing on the COMMIT edge
    @(negedge clk);
    req_valid = 1'b1; req_row = 3'd6; req_col = 3'd2; req_dir = 2'b00; chk_allow = 3'b100;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk) new_game = 1'b1;
    @(posedge clk);
    @(negedge clk) new_game = 1'b0;
    exp_b = start_b; exp_turn = 1'b0;
    check("ngc.board", board, start_b);
    check("ngc.turn", turn, 1'b0);
    check("ngc.valid", resp_valid, 1'b0);
    check("ngc.ready", req_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("ngc.valid_later", resp_valid, 1'b0);

    // new_game beats a same-cycle request
    @(negedge clk);
    new_game = 1'b1; req_valid = 1'b1; req_row = 3'd6; req_col = 3'd3; req_dir = 2'b00;
    @(posedge clk);
    @(negedge clk) begin new_game = 1'b0; req_valid = 1'b0; end
    check("ngr.ready", req_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("ngr.valid", resp_valid, 1'b0);
    check("ngr.board", board, start_b);

    // async reset while in CHECK
    run_step("s24", 3'd6, 3'd3, 2'b00, 3'b100, 2'b00, 3'd5, 3'd3, 5'b00000, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_row = 3'd1; req_col = 3'd1; req_dir = 2'b00; chk_allow = 3'b100;
    @(posedge clk);
    @(negedge clk) begin req_valid = 1'b0; rst_n = 1'b0; end
    #1;
    check("arst.board", board, start_b);
    check("arst.turn", turn, 1'b0);
    check("arst.valid", resp_valid, 1'b0);
    check("arst.ready", req_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst.valid_later", resp_valid, 1'b0);
    check("arst.board_later", board, start_b);
    exp_b = start_b; exp_turn = 1'b0;

    run_step("s25", 3'd6, 3'd4, 2'b00, 3'b100, 2'b00, 3'd5, 3'd4, 5'b00000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
